bus_arbiter_rr: RTL and testbench
=================================

Name: bus_arbiter_rr

Overview:
N-port round-robin bus arbiter. It merges any number of requester channels (per-hart IM/DM ports, DMA, debug) onto the single `BUS_M` master interface, and supersedes the fixed two-channel IM/DM bus bridge. Each transaction is fully registered and held until the slave acks; at most one transaction is outstanding. Instantiated in multi-hart top levels between the hart memory ports and the system bus.

Parameters:
N_PORTS, 3, number of requester channels (2..16)
XLEN, `XLEN, address/data width
TIMEOUT_CYCLES, 256, ack watchdog limit, used only with ARVI_BUS_TIMEOUT_EN

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous reset, active-high
i_req  in  N_PORTS  per-channel request, level
i_wr_en  in  N_PORTS  per-channel write (1) / read (0)
i_addr  in  N_PORTS*XLEN  packed per-channel address, channel k at [k*XLEN +: XLEN]
i_wr_data  in  N_PORTS*XLEN  packed per-channel write data
i_byte_en  in  N_PORTS*(XLEN/8)  packed per-channel byte enables
o_ready  out  N_PORTS  one-cycle completion pulse, at most one bit set
o_rd_data  out  XLEN  read data, broadcast, valid with o_ready
o_err  out  1  completion was a timeout abort, valid with o_ready
i_ack  in  1  bus slave ack, one cycle
i_rd_data  in  XLEN  bus read data, sampled on i_ack
o_bus_en  out  1  bus transaction active
o_wr_en  out  1  bus write
o_wr_data  out  XLEN  bus write data
o_addr  out  XLEN  bus address
o_byte_en  out  XLEN/8  bus byte enables

Behaviour:
- Clock and reset: one clock i_clk. Reset i_rst is synchronous and active-high.
- Reset values: all outputs 0; state IDLE; rr pointer 0; grant index 0; timeout counter 0.
- States: IDLE, BUSY, RESP.
- IDLE: if any i_req, select winner = first set bit scanning from pointer upward, modulo N_PORTS. Register grant, wr_en, addr, wr_data, byte_en from the winner. Go to BUSY. No request: stay in IDLE.
- BUSY: o_bus_en=1. o_wr_en/o_addr/o_wr_data/o_byte_en driven from the registered copy and stable throughout. On i_ack: capture i_rd_data (writes capture it too; value don't-care), set pointer = (grant+1) mod N_PORTS, go to RESP.
- RESP: o_bus_en=0. o_ready[grant]=1 for exactly this cycle. o_rd_data = captured data. Next state IDLE.
- Latency: req seen in IDLE at cycle 0 -> o_bus_en at cycle 1. Ack at cycle k -> o_ready at k+1. Earliest new grant decided at k+2 (one turnaround cycle).
- Requester protocol: hold i_req and its fields until its o_ready pulse, then deassert or present the next request the same cycle.
- Request dropped while BUSY: ignored. The transaction completes and o_ready still pulses.
- i_ack outside BUSY: ignored.
- o_rd_data holds its last value outside RESP.
- Fairness: with all channels requesting continuously, grants rotate 0,1,..,N-1,0. No channel waits more than N_PORTS-1 transactions.
- Pointer advances only on completion, never on grant.
- Reset mid-transaction: state returns to IDLE next edge, o_bus_en drops, no o_ready pulse. Any late i_ack is ignored.
- N_PORTS=1: degenerate arbiter, pointer constant 0.

Optional Feature:
ARVI_BUS_TIMEOUT_EN
- Defined: counter clears on entering BUSY and increments each BUSY cycle without i_ack. When the count reaches TIMEOUT_CYCLES-1 without ack, go to RESP with o_err=1 and o_rd_data=0; the pointer advances normally. Ack on the same cycle as expiry wins: normal completion, o_err=0.
- Undefined: no counter logic, BUSY waits indefinitely, o_err tied 0.

Decomposition:
- Shared package arvi_bus_pkg: state enum (IDLE/BUSY/RESP), bus request struct {wr_en, addr, wr_data, byte_en}, localparam BE_W = XLEN/8.
- One sub-module rr_picker (combinational): inputs req vector and pointer, outputs one-hot/index winner and any-valid flag. It is reusable by future interrupt arbiters.

Test Plan:
- Single read, N_PORTS=3: req[1], addr 0x0000_1000; ack 3 cycles after o_bus_en with rd 0xDEAD_BEEF -> o_addr=0x1000, o_wr_en=0, o_ready=3'b010 one cycle, o_rd_data=0xDEAD_BEEF.
- Round robin: req=3'b111 held, each completion re-requests -> grant order 0,1,2,0,1,2; each o_ready one-hot, one idle cycle between transactions.
- Write with byte enables: ch2 write addr 0x20, data 0x1122_3344, be 4'b0011 -> bus fields match exactly and stay stable until ack; o_ready[2] at ack+1.
- Reset mid-transaction: i_rst asserted while BUSY -> next cycle all outputs 0, no o_ready. A later ack is ignored, and a fresh req[0] is granted (pointer 0).
- Request withdrawn: ch0 drops req 1 cycle into BUSY -> bus transaction continues, o_ready[0] still pulses after ack.
- Timeout (ARVI_BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8): no ack -> o_ready and o_err high together, 8 cycles after o_bus_en rises, o_rd_data=0. Ack on expiry cycle -> o_err=0.

Source files
------------

// File: rtl/arvi_bus_pkg.sv
// arvi_bus_pkg: shared types for the round-robin bus arbiter.
//   bus_state_e : arbiter FSM states (IDLE/BUSY/RESP)
//   bus_req_t   : registered bus request {wr_en, addr, wr_data, byte_en}
//   BE_W        : byte-enable width derived from XLEN
`ifndef XLEN
`define XLEN 32
`endif
package arvi_bus_pkg;
    localparam int XLEN_DEF = `XLEN;
    localparam int BE_W = XLEN_DEF / 8;
    typedef enum logic [1:0] {IDLE, BUSY, RESP} bus_state_e;
    typedef struct packed {
        logic                wr_en;
        logic [XLEN_DEF-1:0] addr;
        logic [XLEN_DEF-1:0] wr_data;
        logic [BE_W-1:0]     byte_en;
    } bus_req_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin winner select.
//   i_req    : request vector
//   i_ptr    : highest-priority index
//   o_onehot : winner as one-hot
//   o_idx    : winner index
//   o_valid  : any request present
module rr_picker #(
    parameter int N  = 3,
    parameter int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic [N-1:0]  o_onehot,
    output logic [IW-1:0] o_idx,
    output logic          o_valid
);
    logic [IW-1:0] k;
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        k        = '0;
        // Scan from farthest to nearest so the request closest to the pointer is written last and wins.
        for (int j = N - 1; j >= 0; j--) begin
            k = IW'((int'(i_ptr) + j) % N);
            if (i_req[k]) begin
                o_onehot    = '0;
                o_onehot[k] = 1'b1;
                o_idx       = k;
                o_valid     = 1'b1;
            end
        end
    end
endmodule

// File: rtl/bus_arbiter_rr.sv
// bus_arbiter_rr: N-port round-robin arbiter onto a single bus master.
//   i_clk/i_rst                                  : clock, synchronous active-high reset
//   i_req/i_wr_en/i_addr/i_wr_data/i_byte_en     : packed per-channel requests
//   o_ready/o_rd_data/o_err                      : per-channel completion pulse and response
//   i_ack/i_rd_data                              : bus slave response
//   o_bus_en/o_wr_en/o_wr_data/o_addr/o_byte_en  : bus master request
// Optional: define ARVI_BUS_TIMEOUT_EN to abort transactions unacked for TIMEOUT_CYCLES.
`ifndef XLEN
`define XLEN 32
`endif
module bus_arbiter_rr
    import arvi_bus_pkg::*;
#(
    parameter int N_PORTS        = 3,
    parameter int XLEN           = `XLEN,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic [N_PORTS-1:0]          i_req,
    input  logic [N_PORTS-1:0]          i_wr_en,
    input  logic [N_PORTS*XLEN-1:0]     i_addr,
    input  logic [N_PORTS*XLEN-1:0]     i_wr_data,
    input  logic [N_PORTS*(XLEN/8)-1:0] i_byte_en,
    output logic [N_PORTS-1:0]          o_ready,
    output logic [XLEN-1:0]             o_rd_data,
    output logic                        o_err,
    input  logic                        i_ack,
    input  logic [XLEN-1:0]             i_rd_data,
    output logic                        o_bus_en,
    output logic                        o_wr_en,
    output logic [XLEN-1:0]             o_wr_data,
    output logic [XLEN-1:0]             o_addr,
    output logic [XLEN/8-1:0]           o_byte_en
);
    localparam int IW = (N_PORTS > 1) ? $clog2(N_PORTS) : 1;

    bus_state_e         state_q, state_d;
    logic [IW-1:0]      ptr_q, ptr_d, grant_q, grant_d, ptr_next, win_idx;
    logic [N_PORTS-1:0] grant_oh_q, grant_oh_d, win_oh;
    logic               win_valid;
    bus_req_t           req_q, req_d;
    logic [XLEN-1:0]    rd_q, rd_d;

    rr_picker #(.N(N_PORTS), .IW(IW)) u_picker (
        .i_req   (i_req),
        .i_ptr   (ptr_q),
        .o_onehot(win_oh),
        .o_idx   (win_idx),
        .o_valid (win_valid)
    );

    assign ptr_next = (int'(grant_q) == N_PORTS - 1) ? '0 : grant_q + 1'b1;

`ifdef ARVI_BUS_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    logic          expire;
    assign expire = (cnt_q == CW'(TIMEOUT_CYCLES - 1));
    assign o_err  = (state_q == RESP) & err_q;
`else
    assign o_err  = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        grant_d    = grant_q;
        grant_oh_d = grant_oh_q;
        req_d      = req_q;
        rd_d       = rd_q;
`ifdef ARVI_BUS_TIMEOUT_EN
        cnt_d      = cnt_q;
        err_d      = err_q;
`endif
        if (state_q == IDLE && win_valid) begin
            state_d    = BUSY;
            grant_d    = win_idx;
            grant_oh_d = win_oh;
            req_d      = '{wr_en:   i_wr_en[win_idx],
                           addr:    i_addr[int'(win_idx)*XLEN +: XLEN],
                           wr_data: i_wr_data[int'(win_idx)*XLEN +: XLEN],
                           byte_en: i_byte_en[int'(win_idx)*BE_W +: BE_W]};
`ifdef ARVI_BUS_TIMEOUT_EN
            cnt_d      = '0;
`endif
        end else if (state_q == BUSY && i_ack) begin
            state_d = RESP;
            ptr_d   = ptr_next;
            rd_d    = i_rd_data;
`ifdef ARVI_BUS_TIMEOUT_EN
            err_d   = 1'b0;
        end else if (state_q == BUSY && expire) begin
            state_d = RESP;
            ptr_d   = ptr_next;
            rd_d    = '0;
            err_d   = 1'b1;
        end else if (state_q == BUSY) begin
            cnt_d   = cnt_q + 1'b1;
`endif
        end else if (state_q == RESP) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= IDLE;
            ptr_q      <= '0;
            grant_q    <= '0;
            grant_oh_q <= '0;
            req_q      <= '0;
            rd_q       <= '0;
`ifdef ARVI_BUS_TIMEOUT_EN
            cnt_q      <= '0;
            err_q      <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            grant_q    <= grant_d;
            grant_oh_q <= grant_oh_d;
            req_q      <= req_d;
            rd_q       <= rd_d;
`ifdef ARVI_BUS_TIMEOUT_EN
            cnt_q      <= cnt_d;
            err_q      <= err_d;
`endif
        end
    end

    assign o_bus_en  = (state_q == BUSY);
    assign o_ready   = (state_q == RESP) ? grant_oh_q : '0;
    assign o_rd_data = rd_q;
    assign o_wr_en   = req_q.wr_en;
    assign o_addr    = req_q.addr;
    assign o_wr_data = req_q.wr_data;
    assign o_byte_en = req_q.byte_en;
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb_bus_arbiter_rr: directed plus randomized checks of bus_arbiter_rr against a transaction-level model.
module tb_bus_arbiter_rr;
    localparam int N   = 3;
    localparam int XL  = 32;
    localparam int BW  = XL / 8;
    localparam int TMO = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [N-1:0]      req = '0;
    logic [N-1:0]      i_wr_en;
    logic [N*XL-1:0]   i_addr, i_wr_data;
    logic [N*BW-1:0]   i_byte_en;
    logic [N-1:0]      o_ready;
    logic [XL-1:0]     o_rd_data, i_rd_data = '0, o_wr_data, o_addr;
    logic              o_err, ack = 1'b0, o_bus_en, o_wr_en;
    logic [BW-1:0]     o_byte_en;

    logic [XL-1:0] ch_addr [N];
    logic [XL-1:0] ch_data [N];
    logic [BW-1:0] ch_be   [N];
    logic          ch_wr   [N];

    always #5 clk = ~clk;

    always_comb begin
        i_wr_en = '0; i_addr = '0; i_wr_data = '0; i_byte_en = '0;
        for (int k = 0; k < N; k++) begin
            i_wr_en[k]              = ch_wr[k];
            i_addr[k*XL +: XL]      = ch_addr[k];
            i_wr_data[k*XL +: XL]   = ch_data[k];
            i_byte_en[k*BW +: BW]   = ch_be[k];
        end
    end

    bus_arbiter_rr #(.N_PORTS(N), .XLEN(XL), .TIMEOUT_CYCLES(TMO)) dut (
        .i_clk(clk), .i_rst(rst), .i_req(req), .i_wr_en(i_wr_en), .i_addr(i_addr),
        .i_wr_data(i_wr_data), .i_byte_en(i_byte_en), .o_ready(o_ready), .o_rd_data(o_rd_data),
        .o_err(o_err), .i_ack(ack), .i_rd_data(i_rd_data), .o_bus_en(o_bus_en), .o_wr_en(o_wr_en),
        .o_wr_data(o_wr_data), .o_addr(o_addr), .o_byte_en(o_byte_en)
    );

    int checks = 0, errors = 0;
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Transaction-level model: phase 0 waiting, 1 on the bus, 2 reporting completion.
    int            m_phase = 0, m_ptr = 0, m_owner = 0, m_wait = 0;
    logic [XL-1:0] m_rd = '0, m_addr = '0, m_wdata = '0;
    logic [BW-1:0] m_be = '0;
    logic          m_wr = 1'b0, m_err = 1'b0;
    bit            cmp_en = 0;
    int            wcnt [N];

    initial forever begin
        @(posedge clk);
        if (rst) begin
            m_phase = 0; m_ptr = 0; m_owner = 0; m_wait = 0;
            m_rd = '0; m_addr = '0; m_wdata = '0; m_be = '0; m_wr = 1'b0; m_err = 1'b0;
        end else if (m_phase == 0) begin
            if (req != '0) begin
                for (int j = 0; j < N; j++)
                    if (req[(m_ptr + j) % N]) begin m_owner = (m_ptr + j) % N; break; end
                m_addr = ch_addr[m_owner]; m_wdata = ch_data[m_owner];
                m_be = ch_be[m_owner]; m_wr = ch_wr[m_owner];
                m_phase = 1; m_wait = 0;
            end
        end else if (m_phase == 1) begin
            if (ack) begin
                m_rd = i_rd_data; m_err = 1'b0; m_ptr = (m_owner + 1) % N; m_phase = 2;
`ifdef ARVI_BUS_TIMEOUT_EN
            end else if (m_wait == TMO - 1) begin
                m_rd = '0; m_err = 1'b1; m_ptr = (m_owner + 1) % N; m_phase = 2;
`endif
            end else begin
                m_wait++;
            end
        end else begin
            m_phase = 0;
        end
    end

    initial forever begin
        @(negedge clk);
        if (cmp_en) begin
            chk("bus_en", o_bus_en, m_phase == 1);
            chk("ready", o_ready, m_phase == 2 ? (64'd1 << m_owner) : 64'd0);
            chk("rd_data", o_rd_data, m_rd);
            chk("err", o_err, m_phase == 2 && m_err);
            chk("addr", o_addr, m_addr);
            chk("wr_data", o_wr_data, m_wdata);
            chk("byte_en", o_byte_en, m_be);
            chk("wr_en", o_wr_en, m_wr);
            chk("ready_onehot", $countones(o_ready) <= 1, 1);
            if (rst) foreach (wcnt[k]) wcnt[k] = 0;
            else if (o_ready != '0)
                for (int k = 0; k < N; k++) begin
                    if (o_ready[k]) wcnt[k] = 0;
                    else if (req[k]) begin
                        wcnt[k]++;
                        chk("fair_wait", wcnt[k] <= N - 1, 1);
                    end
                end
        end
    end

    task automatic step();
        @(negedge clk); #1;
    endtask

    task automatic wait_bus();
        int n = 0;
        while (!o_bus_en && n < 50) begin step(); n++; end
        chk("bus_en_wait", o_bus_en, 1);
    endtask

    task automatic do_reset();
        rst = 1; req = '0; ack = 0;
        step(); step();
        rst = 0;
    endtask

    initial begin
        foreach (wcnt[k]) wcnt[k] = 0;
        for (int k = 0; k < N; k++) begin
            ch_addr[k] = '0; ch_data[k] = '0; ch_be[k] = '0; ch_wr[k] = 1'b0;
        end
        do_reset();
        cmp_en = 1;
        chk("rst_bus_en", o_bus_en, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_rd_data", o_rd_data, 0);
        chk("rst_addr", o_addr, 0);
        chk("rst_err", o_err, 0);

        // Single read on channel 1, ack three cycles after the bus goes active.
        ch_addr[1] = 32'h0000_1000; ch_wr[1] = 0; req = 3'b010;
        wait_bus();
        chk("rd_addr", o_addr, 32'h1000);
        chk("rd_wr_en", o_wr_en, 0);
        step(); step(); step();
        ack = 1; i_rd_data = 32'hDEAD_BEEF;
        step();
        ack = 0;
        chk("rd_ready", o_ready, 3'b010);
        chk("rd_data_lit", o_rd_data, 32'hDEAD_BEEF);
        req = '0;
        step();
        chk("rd_ready_once", o_ready, 0);
        chk("rd_hold", o_rd_data, 32'hDEAD_BEEF);

        // All channels requesting continuously rotate 0,1,2,0,1,2 with one idle cycle between.
        do_reset();
        for (int k = 0; k < N; k++) ch_addr[k] = 32'h100 * (k + 1);
        req = 3'b111;
        for (int t = 0; t < 6; t++) begin
            wait_bus();
            chk("rr_addr", o_addr, 32'h100 * (t % 3 + 1));
            ack = 1; i_rd_data = t;
            step();
            ack = 0;
            chk("rr_ready", o_ready, 3'b001 << (t % 3));
            step();
            chk("rr_turnaround", o_bus_en, 0);
        end
        req = '0;

        // Write with partial byte enables, fields stable until ack.
        do_reset();
        ch_addr[2] = 32'h20; ch_data[2] = 32'h1122_3344; ch_be[2] = 4'b0011; ch_wr[2] = 1;
        req = 3'b100;
        wait_bus();
        for (int t = 0; t < 3; t++) begin
            chk("wr_addr", o_addr, 32'h20);
            chk("wr_data_lit", o_wr_data, 32'h1122_3344);
            chk("wr_be", o_byte_en, 4'b0011);
            chk("wr_en_lit", o_wr_en, 1);
            step();
        end
        ack = 1;
        step();
        ack = 0;
        chk("wr_ready", o_ready, 3'b100);
        req = '0;
        step();

        // Reset while the bus is busy, then a late ack, then a fresh grant from pointer 0.
        do_reset();
        ch_addr[1] = 32'h77; ch_wr[1] = 0; req = 3'b010;
        wait_bus();
        step();
        rst = 1;
        step();
        rst = 0; req = '0;
        chk("rmid_bus_en", o_bus_en, 0);
        chk("rmid_ready", o_ready, 0);
        chk("rmid_addr", o_addr, 0);
        ack = 1;
        step();
        ack = 0;
        chk("late_ack_ready", o_ready, 0);
        step();
        chk("late_ack_ready2", o_ready, 0);
        ch_addr[0] = 32'h40; ch_wr[0] = 0; req = 3'b011;
        wait_bus();
        chk("fresh_grant", o_addr, 32'h40);
        ack = 1;
        step();
        ack = 0;
        chk("fresh_ready", o_ready, 3'b001);
        req = '0;
        step();

        // Channel 0 withdraws its request one cycle into the transaction.
        do_reset();
        req = 3'b001;
        wait_bus();
        step();
        req = '0;
        step(); step();
        chk("drop_busy", o_bus_en, 1);
        ack = 1;
        step();
        ack = 0;
        chk("drop_ready", o_ready, 3'b001);
        step();

`ifdef ARVI_BUS_TIMEOUT_EN
        do_reset();
        req = 3'b001;
        wait_bus();
        for (int t = 0; t < TMO - 1; t++) step();
        chk("tmo_still_busy", o_bus_en, 1);
        step();
        chk("tmo_ready", o_ready, 3'b001);
        chk("tmo_err", o_err, 1);
        chk("tmo_rd", o_rd_data, 0);
        step();
        wait_bus();
        for (int t = 0; t < TMO - 1; t++) step();
        ack = 1; i_rd_data = 32'h55;
        step();
        ack = 0;
        chk("tmo_ack_ready", o_ready, 3'b001);
        chk("tmo_ack_err", o_err, 0);
        chk("tmo_ack_rd", o_rd_data, 32'h55);
        req = '0;
        step();
`endif

        // Randomized traffic with occasional withdrawals and resets, checked by the model.
        do_reset();
        foreach (wcnt[k]) wcnt[k] = 0;
        for (int c = 0; c < 4000; c++) begin
            for (int k = 0; k < N; k++) begin
                if (o_ready[k] && req[k] && $urandom_range(0, 1) == 0) req[k] = 0;
                else if ((!req[k] || o_ready[k]) && !(m_phase == 1 && m_owner == k)
                         && $urandom_range(0, 3) == 0) begin
                    req[k] = 1;
                    ch_addr[k] = $urandom; ch_data[k] = $urandom;
                    ch_be[k] = BW'($urandom); ch_wr[k] = 1'($urandom);
                end else if (m_phase == 1 && m_owner == k && $urandom_range(0, 15) == 0) req[k] = 0;
            end
            ack = ($urandom_range(0, 2) == 0);
            i_rd_data = $urandom;
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0; ack = 0; req = '0;
        step(); step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
